// File: rtl/hongwai_rx.sv
// ---------------------------------------------------------------------------
// hongwai_rx - infrared receiver/decoder for the air-conditioner remote frame
//
// Frame on the line (0 = mark / carrier, 1 = space):
//   header mark, header space, 35 x (bit mark, bit space), connect mark,
//   connect space, 32 x (bit mark, bit space), stop mark.
// A bit's value is carried by the length of its space. Both data words
// are presented together with a one-cycle frame_valid strobe.
//
// Parameters
//   T_US      clock cycles per microsecond
//   FILT_CYC  cycles the synchronized input must be stable before the
//             filtered level follows it
//   WIN_DIV   divisor applied to every timing window (1 = nominal protocol
//             timing; larger values compress the protocol time base)
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   ir_in        demodulated IR line, asynchronous (0 = mark, 1 = space)
//   data35       first block, first received bit in bit 34
//   data32       second block, first received bit in bit 31
//   frame_valid  one-cycle pulse, data35/data32 updated on the same cycle
//   frame_err    one-cycle pulse on a protocol violation after a header
//   err_code     stage of the last error: 1 header space, 2 bit/connect/stop
//                mark, 3 bit space, 4 connect space
//   busy         high from header acceptance until valid or error
// ---------------------------------------------------------------------------
module hongwai_rx #(
    parameter int T_US     = 125,
    parameter int FILT_CYC = 64,
    parameter int WIN_DIV  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ir_in,
    output logic [34:0] data35,
    output logic [31:0] data32,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [2:0]  err_code,
    output logic        busy
);

    localparam int PW = (T_US > 1) ? $clog2(T_US) : 1;
    localparam int FW = $clog2(FILT_CYC + 1);

    localparam logic [PW-1:0] PRE_LAST  = PW'(T_US - 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILT_CYC - 1);

    // Acceptance windows in microseconds, inclusive on both ends.
    localparam logic [15:0] HM_MIN   = 16'(7500  / WIN_DIV);
    localparam logic [15:0] HM_MAX   = 16'(10500 / WIN_DIV);
    localparam logic [15:0] HS_MIN   = 16'(3500  / WIN_DIV);
    localparam logic [15:0] HS_MAX   = 16'(5500  / WIN_DIV);
    localparam logic [15:0] BM_MIN   = 16'(400   / WIN_DIV);
    localparam logic [15:0] BM_MAX   = 16'(1100  / WIN_DIV);
    localparam logic [15:0] ZERO_MIN = 16'(200   / WIN_DIV);
    localparam logic [15:0] ZERO_MAX = 16'(800   / WIN_DIV);
    localparam logic [15:0] ONE_MIN  = 16'(1100  / WIN_DIV);
    localparam logic [15:0] ONE_MAX  = 16'(2000  / WIN_DIV);
    localparam logic [15:0] CS_MIN   = 16'(17000 / WIN_DIV);
    localparam logic [15:0] CS_MAX   = 16'(23000 / WIN_DIV);

    typedef enum logic [3:0] {
        IDLE,
        HDR_MARK,
        HDR_SPACE,
        B35_MARK,
        B35_SPACE,
        CONN_MARK,
        CONN_SPACE,
        B32_MARK,
        B32_SPACE,
        STOP_MARK
    } state_t;

    function automatic logic in_win(input logic [15:0] d,
                                    input logic [15:0] lo,
                                    input logic [15:0] hi);
        return (d >= lo) && (d <= hi);
    endfunction

    // IDLE and HDR_MARK are pre-header states: nothing has been accepted yet,
    // so they never raise errors and do not count as busy.
    function automatic logic is_busy(input state_t s);
        return !((s == IDLE) || (s == HDR_MARK));
    endfunction

    state_t        state;
    state_t        state_nxt;

    logic          ir_p0;
    logic          ir_p1;
    logic          filt_p2;
    logic          filt_p3;
    logic [FW-1:0] filt_cnt;
    logic          edge_any;
    logic          edge_fall;
    logic          edge_rise;

    logic [PW-1:0] pre;
    logic          tick;
    logic [15:0]   dur_us;

    logic [34:0]   sh35;
    logic [31:0]   sh32;
    logic [5:0]    bit_cnt;

    logic          in_busy;
    logic          edge_ok;
    logic          timeout;
    logic          bit_one;
    logic [15:0]   st_max;
    logic [2:0]    st_code;

    logic          err_set;
    logic          valid_set;
    logic          shift35;
    logic          shift32;
    logic          load35;
    logic          load32;

    // Stage p0/p1: two-flop synchronizer. Stage p2: stability filter.
    // Stage p3: previous filtered level for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_p0    <= 1'b1;
            ir_p1    <= 1'b1;
            filt_p2  <= 1'b1;
            filt_p3  <= 1'b1;
            filt_cnt <= '0;
        end else begin
            ir_p0   <= ir_in;
            ir_p1   <= ir_p0;
            filt_p3 <= filt_p2;
            if (ir_p1 == filt_p2) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_LAST) begin
                filt_p2  <= ir_p1;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign edge_any  = (filt_p2 != filt_p3);
    assign edge_fall = edge_any & ~filt_p2;
    assign edge_rise = edge_any &  filt_p2;
    assign tick      = (pre == PRE_LAST);

    // Duration timer: restarts on every edge, so at an edge dur_us holds the
    // length of the level that just ended.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre    <= '0;
            dur_us <= '0;
        end else if (edge_any) begin
            pre    <= '0;
            dur_us <= '0;
        end else if (tick) begin
            pre <= '0;
            if (dur_us != 16'hFFFF) begin
                dur_us <= dur_us + 16'd1;
            end
        end else begin
            pre <= pre + 1'b1;
        end
    end

    // Per-state window decode. Levels alternate, so in a busy state the next
    // edge is always the one that ends the current level; direction need not
    // be checked there.
    always_comb begin
        st_max  = 16'hFFFF;
        st_code = 3'd0;
        edge_ok = 1'b0;
        bit_one = 1'b0;
        case (state)
            HDR_SPACE: begin
                st_max  = HS_MAX;
                st_code = 3'd1;
                edge_ok = in_win(dur_us, HS_MIN, HS_MAX);
            end
            B35_MARK, CONN_MARK, B32_MARK, STOP_MARK: begin
                st_max  = BM_MAX;
                st_code = 3'd2;
                edge_ok = in_win(dur_us, BM_MIN, BM_MAX);
            end
            B35_SPACE, B32_SPACE: begin
                st_max  = ONE_MAX;
                st_code = 3'd3;
                bit_one = in_win(dur_us, ONE_MIN, ONE_MAX);
                // The 800..1100 gap between the two windows is rejected.
                edge_ok = bit_one || in_win(dur_us, ZERO_MIN, ZERO_MAX);
            end
            CONN_SPACE: begin
                st_max  = CS_MAX;
                st_code = 3'd4;
                edge_ok = in_win(dur_us, CS_MIN, CS_MAX);
            end
            default: ;
        endcase
        in_busy = is_busy(state);
        // Fires without waiting for an edge once the level is already too long.
        timeout = in_busy && (dur_us > st_max);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (in_busy && (timeout || (edge_any && !edge_ok))) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                // Only a falling edge arms the receiver, so a mark already in
                // progress after an error or reset is never taken as a header.
                IDLE:       if (edge_fall) state_nxt = HDR_MARK;
                HDR_MARK:   if (edge_rise) state_nxt = in_win(dur_us, HM_MIN, HM_MAX) ? HDR_SPACE : IDLE;
                HDR_SPACE:  if (edge_any)  state_nxt = B35_MARK;
                B35_MARK:   if (edge_any)  state_nxt = B35_SPACE;
                B35_SPACE:  if (edge_any)  state_nxt = (bit_cnt == 6'd0) ? CONN_MARK : B35_MARK;
                CONN_MARK:  if (edge_any)  state_nxt = CONN_SPACE;
                CONN_SPACE: if (edge_any)  state_nxt = B32_MARK;
                B32_MARK:   if (edge_any)  state_nxt = B32_SPACE;
                B32_SPACE:  if (edge_any)  state_nxt = (bit_cnt == 6'd0) ? STOP_MARK : B32_MARK;
                STOP_MARK:  if (edge_any)  state_nxt = IDLE;
                default:                   state_nxt = IDLE;
            endcase
        end
    end

    // Output / datapath control decode
    always_comb begin
        err_set   = in_busy && (timeout || (edge_any && !edge_ok));
        valid_set = !err_set && edge_any && (state == STOP_MARK);
        shift35   = !err_set && edge_any && (state == B35_SPACE);
        shift32   = !err_set && edge_any && (state == B32_SPACE);
        load35    = !err_set && edge_any && (state == HDR_SPACE);
        load32    = !err_set && edge_any && (state == CONN_SPACE);
    end

    // Stage: bit assembly. Bits enter at the LSB so the first bit received
    // ends up in the MSB after the final shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
        end else if (load35) begin
            bit_cnt <= 6'd34;
        end else if (load32) begin
            bit_cnt <= 6'd31;
        end else if (shift35 || shift32) begin
            bit_cnt <= bit_cnt - 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (shift35) begin
            sh35 <= {sh35[33:0], bit_one};
        end
        if (shift32) begin
            sh32 <= {sh32[30:0], bit_one};
        end
    end

    // Stage: registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            data35      <= '0;
            data32      <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= '0;
            busy        <= 1'b0;
        end else begin
            frame_valid <= valid_set;
            frame_err   <= err_set;
            busy        <= is_busy(state_nxt);
            if (err_set) begin
                err_code <= st_code;
            end
            if (valid_set) begin
                data35 <= sh35;
                data32 <= sh32;
            end
        end
    end

endmodule
